// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the RegisterFile: WB stage has fixed priority, the multi-cycle unit
// is handshaked and parked in an in-order buffer when it loses. Optional stats: RFARB_STATS_EN.
module regfile_write_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int BUF_DEPTH = 2,
    localparam int CNT_W    = $clog2(BUF_DEPTH) + 1,
    localparam int PTR_W    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              WbValid,
    input  logic [ADDR_W-1:0] WbReg,
    input  logic [DATA_W-1:0] WbData,
    input  logic              MuValid,
    input  logic [ADDR_W-1:0] MuReg,
    input  logic [DATA_W-1:0] MuData,
    output logic              MuReady,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteRegister,
    output logic [DATA_W-1:0] WriteData,
    output logic [CNT_W-1:0]  BufCount
`ifdef RFARB_STATS_EN
    ,
    output logic [15:0]       WbWrCnt,
    output logic [15:0]       MuWrCnt,
    output logic [15:0]       ConflictCnt
`endif
);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == PTR_W'(BUF_DEPTH - 1)) begin
            r = '0;
        end else begin
            r = p + PTR_W'(1);
        end
        return r;
    endfunction

    logic [ADDR_W-1:0]    mem_reg_q  [BUF_DEPTH];
    logic [DATA_W-1:0]    mem_data_q [BUF_DEPTH];
    logic [BUF_DEPTH-1:0] vld_q, vld_d;
    logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] wr_reg_q, wr_reg_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic mu_ready_s, mu_acc_s, mu_live_s, wb_live_s;
    logic push_s, pop_s, issue_mu_s;

    // Grant selection, buffer bookkeeping and squash of stale buffered entries
    always_comb begin
        mu_ready_s = (cnt_q < CNT_W'(BUF_DEPTH));
        mu_acc_s   = MuValid & mu_ready_s;
        mu_live_s  = mu_acc_s & (MuReg != '0);
        wb_live_s  = WbValid & (WbReg != '0);

        rw_d       = 1'b0;
        wr_reg_d   = wr_reg_q;
        wr_data_d  = wr_data_q;
        push_s     = 1'b0;
        pop_s      = 1'b0;
        issue_mu_s = 1'b0;
        vld_d      = vld_q;

        if (wb_live_s) begin
            rw_d      = 1'b1;
            wr_reg_d  = WbReg;
            wr_data_d = WbData;
            push_s    = mu_live_s;
            // Buffered MU results are older than this WB write, so they must never land
            for (int i = 0; i < BUF_DEPTH; i++) begin
                if (mem_reg_q[i] == WbReg) begin
                    vld_d[i] = 1'b0;
                end else begin
                    vld_d[i] = vld_q[i];
                end
            end
        end else if (cnt_q != '0) begin
            pop_s      = 1'b1;
            rw_d       = vld_q[head_q];
            issue_mu_s = vld_q[head_q];
            wr_reg_d   = mem_reg_q[head_q];
            wr_data_d  = mem_data_q[head_q];
            push_s     = mu_live_s;
        end else if (mu_live_s) begin
            rw_d       = 1'b1;
            issue_mu_s = 1'b1;
            wr_reg_d   = MuReg;
            wr_data_d  = MuData;
        end else begin
            rw_d = 1'b0;
        end

        if (push_s) begin
            vld_d[tail_q] = 1'b1;
        end else begin
            vld_d[tail_q] = vld_d[tail_q];
        end

        head_d = pop_s  ? ptr_inc(head_q) : head_q;
        tail_d = push_s ? ptr_inc(tail_q) : tail_q;
        cnt_d  = cnt_q + CNT_W'(push_s) - CNT_W'(pop_s);
    end

    // Buffer storage, pointers and registered write-port outputs
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_reg_q[i]  <= '0;
                mem_data_q[i] <= '0;
            end
            vld_q     <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            cnt_q     <= '0;
            rw_q      <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
        end else begin
            if (push_s) begin
                mem_reg_q[tail_q]  <= MuReg;
                mem_data_q[tail_q] <= MuData;
            end
            vld_q     <= vld_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            cnt_q     <= cnt_d;
            rw_q      <= rw_d;
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign MuReady       = mu_ready_s;
    assign RegWrite      = rw_q;
    assign WriteRegister = wr_reg_q;
    assign WriteData     = wr_data_q;
    assign BufCount      = cnt_q;

`ifdef RFARB_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        logic [15:0] r;
        if (en && (v != 16'hFFFF)) begin
            r = v + 16'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    logic [15:0] wb_cnt_q, mu_cnt_q, cf_cnt_q;

    // Saturating activity counters
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            wb_cnt_q <= 16'd0;
            mu_cnt_q <= 16'd0;
            cf_cnt_q <= 16'd0;
        end else begin
            wb_cnt_q <= sat_inc(wb_cnt_q, wb_live_s);
            mu_cnt_q <= sat_inc(mu_cnt_q, issue_mu_s);
            cf_cnt_q <= sat_inc(cf_cnt_q, WbValid & (MuValid | (cnt_q != '0)));
        end
    end

    assign WbWrCnt     = wb_cnt_q;
    assign MuWrCnt     = mu_cnt_q;
    assign ConflictCnt = cf_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vector table followed by random traffic
// checked against a queue-based reference model.
module tb_regfile_write_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int D  = 2;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wb_valid, mu_valid, mu_ready, reg_write;
    logic [AW-1:0] wb_reg, mu_reg, write_register;
    logic [DW-1:0] wb_data, mu_data, write_data;
    logic [CW-1:0] buf_count;

    int checks = 0;
    int failures = 0;

    regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .BUF_DEPTH(D)) dut (
        .Clk(clk), .Rst_n(rst_n),
        .WbValid(wb_valid), .WbReg(wb_reg), .WbData(wb_data),
        .MuValid(mu_valid), .MuReg(mu_reg), .MuData(mu_data),
        .MuReady(mu_ready), .RegWrite(reg_write),
        .WriteRegister(write_register), .WriteData(write_data),
        .BufCount(buf_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst_n;
        logic          wbv;
        logic [AW-1:0] wbr;
        logic [DW-1:0] wbd;
        logic          muv;
        logic [AW-1:0] mur;
        logic [DW-1:0] mud;
        logic          erw;
        logic [AW-1:0] ereg;
        logic [DW-1:0] edat;
        int            ecnt;
        logic          erdy;
    } vec_t;

    typedef struct {
        logic [AW-1:0] r;
        logic [DW-1:0] d;
        logic          live;
    } ent_t;

    vec_t tbl[$];
    ent_t mq[$];

    function automatic vec_t v(logic rs, logic wv, int wr, int wd, logic mv, int mr, int md,
                               logic rw, int er, int ed, int ec, logic rdy);
        vec_t t;
        t.rst_n = rs; t.wbv = wv; t.wbr = AW'(wr); t.wbd = DW'(wd);
        t.muv = mv; t.mur = AW'(mr); t.mud = DW'(md);
        t.erw = rw; t.ereg = AW'(er); t.edat = DW'(ed); t.ecnt = ec; t.erdy = rdy;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rs, input logic wv, input logic [AW-1:0] wr,
                         input logic [DW-1:0] wd, input logic mv, input logic [AW-1:0] mr,
                         input logic [DW-1:0] md);
        rst_n = rs; wb_valid = wv; wb_reg = wr; wb_data = wd;
        mu_valid = mv; mu_reg = mr; mu_data = md;
    endtask

    task automatic check_outs(input int idx, input logic erw, input logic [AW-1:0] er,
                              input logic [DW-1:0] ed, input int ec, input logic erdy);
        chk("RegWrite", idx, DW'(reg_write), DW'(erw));
        if (erw) begin
            chk("WriteRegister", idx, DW'(write_register), DW'(er));
            chk("WriteData", idx, write_data, ed);
        end
        chk("BufCount", idx, DW'(buf_count), DW'(ec));
        chk("MuReady", idx, DW'(mu_ready), DW'(erdy));
    endtask

    initial begin
        // reset held with WB active
        tbl.push_back(v(1'b0, 1'b1, 3, 32'h77, 1'b0, 0, 0,   1'b0, 0, 0, 0, 1'b1));
        tbl.push_back(v(1'b0, 1'b1, 3, 32'h77, 1'b0, 0, 0,   1'b0, 0, 0, 0, 1'b1));
        // WB only, then bypass
        tbl.push_back(v(1'b1, 1'b1, 1, 1, 1'b0, 0, 0,        1'b1, 1, 1, 0, 1'b1));
        tbl.push_back(v(1'b1, 1'b0, 0, 0, 1'b1, 8, 32'hA5,   1'b1, 8, 32'hA5, 0, 1'b1));
        // conflict
        tbl.push_back(v(1'b1, 1'b1, 9, 5, 1'b1, 10, 7,       1'b1, 9, 5, 1, 1'b1));
        tbl.push_back(v(1'b1, 1'b0, 0, 0, 1'b0, 0, 0,        1'b1, 10, 7, 0, 1'b1));
        tbl.push_back(v(1'b1, 1'b0, 0, 0, 1'b0, 0, 0,        1'b0, 0, 0, 0, 1'b1));
        // fill, stall while full, drain in order
        tbl.push_back(v(1'b1, 1'b1, 1, 32'h10, 1'b1, 11, 32'hB1, 1'b1, 1, 32'h10, 1, 1'b1));
        tbl.push_back(v(1'b1, 1'b1, 2, 32'h20, 1'b1, 12, 32'hB2, 1'b1, 2, 32'h20, 2, 1'b0));
        tbl.push_back(v(1'b1, 1'b1, 3, 32'h30, 1'b1, 13, 32'hB3, 1'b1, 3, 32'h30, 2, 1'b0));
        tbl.push_back(v(1'b1, 1'b1, 4, 32'h40, 1'b1, 13, 32'hB3, 1'b1, 4, 32'h40, 2, 1'b0));
        tbl.push_back(v(1'b1, 1'b0, 0, 0, 1'b1, 13, 32'hB3,  1'b1, 11, 32'hB1, 1, 1'b1));
        tbl.push_back(v(1'b1, 1'b0, 0, 0, 1'b1, 13, 32'hB3,  1'b1, 12, 32'hB2, 1, 1'b1));
        tbl.push_back(v(1'b1, 1'b0, 0, 0, 1'b1, 14, 32'hB4,  1'b1, 13, 32'hB3, 1, 1'b1));
        tbl.push_back(v(1'b1, 1'b0, 0, 0, 1'b0, 0, 0,        1'b1, 14, 32'hB4, 0, 1'b1));
        tbl.push_back(v(1'b1, 1'b0, 0, 0, 1'b0, 0, 0,        1'b0, 0, 0, 0, 1'b1));
        // squash by younger WB, then register 0 handling
        tbl.push_back(v(1'b1, 1'b1, 5, 32'h50, 1'b1, 12, 3,  1'b1, 5, 32'h50, 1, 1'b1));
        tbl.push_back(v(1'b1, 1'b1, 12, 9, 1'b0, 0, 0,       1'b1, 12, 9, 1, 1'b1));
        tbl.push_back(v(1'b1, 1'b0, 0, 0, 1'b0, 0, 0,        1'b0, 0, 0, 0, 1'b1));
        tbl.push_back(v(1'b1, 1'b1, 0, 32'hEE, 1'b0, 0, 0,   1'b0, 0, 0, 0, 1'b1));
        tbl.push_back(v(1'b1, 1'b0, 0, 0, 1'b1, 0, 32'h11,   1'b0, 0, 0, 0, 1'b1));
        tbl.push_back(v(1'b1, 1'b1, 0, 32'h22, 1'b1, 7, 32'h33, 1'b1, 7, 32'h33, 0, 1'b1));
        // reset mid-operation discards the buffer
        tbl.push_back(v(1'b1, 1'b1, 6, 1, 1'b1, 15, 32'hF, 1'b1, 6, 1, 1, 1'b1));
        tbl.push_back(v(1'b0, 1'b0, 0, 0, 1'b0, 0, 0,        1'b0, 0, 0, 0, 1'b1));
        tbl.push_back(v(1'b1, 1'b0, 0, 0, 1'b0, 0, 0,        1'b0, 0, 0, 0, 1'b1));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst_n, tbl[i].wbv, tbl[i].wbr, tbl[i].wbd,
                  tbl[i].muv, tbl[i].mur, tbl[i].mud);
            @(posedge clk);
            #1;
            check_outs(i, tbl[i].erw, tbl[i].ereg, tbl[i].edat, tbl[i].ecnt, tbl[i].erdy);
        end

        // random traffic against a queue model; small register range to hit r0 and squash
        mq.delete();
        for (int c = 0; c < 3000; c++) begin
            logic          rs, wv, mv, acc, erw;
            logic [AW-1:0] wr, mr, er;
            logic [DW-1:0] wd, md, ed;
            ent_t          e;
            rs = (c == 0) ? 1'b0 : ($urandom_range(99) != 0);
            wv = ($urandom_range(2) != 0);
            mv = ($urandom_range(1) != 0);
            wr = AW'($urandom_range(7));
            mr = AW'($urandom_range(7));
            wd = DW'($urandom);
            md = DW'($urandom);
            erw = 1'b0; er = '0; ed = '0;
            if (!rs) begin
                mq.delete();
            end else begin
                acc = mv && (mq.size() < D);
                if (wv && wr != '0) begin
                    erw = 1'b1; er = wr; ed = wd;
                    foreach (mq[k]) if (mq[k].r == wr) mq[k].live = 1'b0;
                end else if (mq.size() > 0) begin
                    e = mq.pop_front();
                    erw = e.live; er = e.r; ed = e.d;
                end else if (acc && mr != '0) begin
                    erw = 1'b1; er = mr; ed = md;
                    acc = 1'b0;
                end
                if (acc && mr != '0) begin
                    e.r = mr; e.d = md; e.live = 1'b1;
                    mq.push_back(e);
                end
            end
            drive(rs, wv, wr, wd, mv, mr, md);
            @(posedge clk);
            #1;
            check_outs(1000 + c, erw, er, ed, mq.size(), mq.size() < D);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
